// File: rtl/cam_pkg.sv
// Shared definitions for the camera capture block: FSM state encoding,
// default frame geometry and the frame-buffer address width.
// Latency: n/a (package). Backpressure: n/a.
package cam_pkg;

   // Capture FSM states
   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,   // waiting for the first frame boundary after reset
      S_BLANK  = 2'd1,   // inside vertical blanking, armed for the next frame
      S_ACTIVE = 2'd2    // capturing pixels of the current frame
   } cam_state_t;

   // Default active geometry (QVGA)
   localparam int H_PIX_DEF   = 320;
   localparam int V_LINES_DEF = 240;

   // Frame-buffer address width: 320*240 = 76800 locations
   localparam int ADDR_W = 17;

   // Width of the x/y position counters; must hold H_PIX+1 and V_LINES
   localparam int CNT_W = 11;

endpackage

// File: rtl/cam_capture.sv
// Captures an RGB565 camera byte stream into frame-buffer write strobes.
// Latency: one cycle from the low (second) byte of a pixel to its write.
// Backpressure: none; the camera cannot be stalled, the buffer must accept every write.
//
// Ports:
//   clk        camera pixel clock, all logic on the rising edge
//   reset      synchronous active-high reset
//   cap_en     permits capture to begin at the next vsync falling edge
//   vsync      frame sync, high during vertical blanking
//   href       line valid, high while active bytes are on data
//   data       camera byte stream, high byte of each pixel first
//   we         frame-buffer write strobe, one cycle per pixel
//   wAddr      frame-buffer write address, y*H_PIX + x
//   wData      RGB565 pixel
//   frame_done one-cycle pulse at the end of each captured frame
//   frame_err  last captured frame was not exactly H_PIX x V_LINES pixels
//   frame_cnt  count of completed frames, wrapping
module cam_capture
   import cam_pkg::*;
#(
   parameter int H_PIX   = H_PIX_DEF,
   parameter int V_LINES = V_LINES_DEF
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              cap_en,
   input  logic              vsync,
   input  logic              href,
   input  logic [7:0]        data,
   output logic              we,
   output logic [ADDR_W-1:0] wAddr,
   output logic [15:0]       wData,
   output logic              frame_done,
   output logic              frame_err,
   output logic [7:0]        frame_cnt
);

   // Geometry constants sized to the counters they are compared against
   localparam logic [CNT_W-1:0]  X_END     = CNT_W'(H_PIX);
   localparam logic [CNT_W-1:0]  X_OVF     = CNT_W'(H_PIX + 1);
   localparam logic [CNT_W-1:0]  Y_END     = CNT_W'(V_LINES);
   localparam logic [ADDR_W-1:0] LINE_STEP = ADDR_W'(H_PIX);

   cam_state_t        state;
   logic              vsync_d;     // previous vsync, for edge detection
   logic              href_d;      // previous href, for end-of-line detection
   logic              phase;       // 0: expecting high byte, 1: expecting low byte
   logic [7:0]        hi_byte;     // high byte of the pixel being assembled
   logic [CNT_W-1:0]  x;           // completed pixels on this line, saturates at H_PIX+1
   logic [CNT_W-1:0]  y;           // completed lines, saturates at V_LINES
   logic [ADDR_W-1:0] line_base;   // y*H_PIX, kept by repeated addition
   logic              line_err;    // some line so far was malformed

   logic              vs_rise;
   logic              vs_fall;
   logic              active;
   logic              pix_done;
   logic              pix_ok;
   logic              line_end;
   logic              line_bad;
   logic [CNT_W-1:0]  y_next;
   logic              err_now;

   assign vs_rise  = vsync & ~vsync_d;
   assign vs_fall  = ~vsync & vsync_d;
   assign active   = (state == S_ACTIVE);

   // A pixel completes on every low byte; it is only written while inside the frame
   assign pix_done = active & href & phase;
   assign pix_ok   = pix_done & (x < X_END) & (y < Y_END);

   // A line is malformed if its pixel count is wrong, or if it arrives after
   // the frame already holds V_LINES lines (y has saturated)
   assign line_end = active & href_d & ~href;
   assign line_bad = line_end & ((x != X_END) | (y == Y_END));
   assign y_next   = (line_end && (y != Y_END)) ? y + 1'b1 : y;

   // Frame verdict, folding in a line that ends in the same cycle as vsync rises
   assign err_now  = line_err | line_bad | (y_next != Y_END);

   always_ff @(posedge clk) begin
      // Edge-detect history is free-running so edges are judged correctly right after reset
      vsync_d <= vsync;
      href_d  <= href;

      if (reset) begin
         state      <= S_IDLE;
         phase      <= 1'b0;
         hi_byte    <= 8'd0;
         x          <= '0;
         y          <= '0;
         line_base  <= '0;
         line_err   <= 1'b0;
         we         <= 1'b0;
         wAddr      <= '0;
         wData      <= 16'd0;
         frame_done <= 1'b0;
         frame_err  <= 1'b0;
         frame_cnt  <= 8'd0;
      end else begin
         we         <= 1'b0;
         frame_done <= 1'b0;

         case (state)
            // The frame in progress at reset is discarded: wait for blanking to start
            S_IDLE: begin
               if (vs_rise) begin
                  state <= S_BLANK;
               end
            end

            S_BLANK: begin
               if (vs_fall && cap_en) begin
                  state     <= S_ACTIVE;
                  phase     <= 1'b0;
                  x         <= '0;
                  y         <= '0;
                  line_base <= '0;
                  line_err  <= 1'b0;
               end
            end

            S_ACTIVE: begin
               // Byte phase restarts on every line, so an odd trailing byte is dropped
               if (!href) begin
                  phase <= 1'b0;
               end else begin
                  phase <= ~phase;
               end

               if (href && !phase) begin
                  hi_byte <= data;
               end

               if (pix_done) begin
                  // Keep counting past the line end only far enough to flag it
                  if (x != X_OVF) begin
                     x <= x + 1'b1;
                  end
                  if (pix_ok) begin
                     we    <= 1'b1;
                     wAddr <= line_base + ADDR_W'(x);
                     wData <= {hi_byte, data};
                  end
               end

               if (line_end) begin
                  x <= '0;
                  y <= y_next;
                  if (y != Y_END) begin
                     line_base <= line_base + LINE_STEP;
                  end
                  if (line_bad) begin
                     line_err <= 1'b1;
                  end
               end

               // Frame end; a pixel completing in this same cycle is still written above
               if (vs_rise) begin
                  state      <= S_BLANK;
                  frame_done <= 1'b1;
                  frame_cnt  <= frame_cnt + 8'd1;
                  frame_err  <= err_now;
               end
            end

            default: begin
               state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_cam_capture.sv
// Directed bench for cam_capture at a reduced frame geometry.
// A per-line pixel model predicts every write, frame_done, frame_cnt and frame_err.
// Literal checks after each scenario pin the model's totals and first/last addresses.
module tb_cam_capture;

   localparam int H = 8;
   localparam int V = 4;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        cap_en = 1'b0;
   logic        vsync = 1'b0;
   logic        href = 1'b0;
   logic [7:0]  data = 8'd0;
   logic        we;
   logic [16:0] wAddr;
   logic [15:0] wData;
   logic        frame_done;
   logic        frame_err;
   logic [7:0]  frame_cnt;

   cam_capture #(.H_PIX(H), .V_LINES(V)) dut (
      .clk        (clk),
      .reset      (reset),
      .cap_en     (cap_en),
      .vsync      (vsync),
      .href       (href),
      .data       (data),
      .we         (we),
      .wAddr      (wAddr),
      .wData      (wData),
      .frame_done (frame_done),
      .frame_err  (frame_err),
      .frame_cnt  (frame_cnt)
   );

   always #5 clk = ~clk;

   typedef struct { int cyc; int addr; int dat; } wr_t;
   typedef struct { int cyc; bit err; } done_t;

   wr_t   exp_wr[$];
   done_t exp_done[$];

   int cyc = 0;
   bit rst_q = 1'b0;
   bit started = 1'b0;
   int checks = 0;
   int errors = 0;

   // Model of the capture rules
   bit m_seen_rise = 1'b0;   // a vsync rise has happened since reset
   bit m_active = 1'b0;      // a frame is being captured
   bit m_line_err = 1'b0;
   int m_lines = 0;          // lines ended in the current frame (not saturated)
   int m_cnt = 0;
   bit m_err = 1'b0;

   // Observations for literal checks
   int n_wr = 0, n_done = 0, first_addr = -1, first_dat = -1, first_cyc = -1, last_addr = -1;
   int lo_cyc = -1;

   always @(posedge clk) begin
      cyc   <= cyc + 1;
      rst_q <= reset;
   end

   task automatic chk(input string name, input longint act, input longint req);
      checks++;
      if (act != req) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, req, cyc);
      end
   endtask

   function automatic logic [7:0] pat(input int l, input int b);
      if (l == 0 && b == 0) return 8'hF8;
      if (l == 0 && b == 1) return 8'h1F;
      return 8'((l * 29 + b * 7 + 3) & 255);
   endfunction

   always @(negedge clk) begin
      wr_t   e;
      done_t d;
      if (started) begin
         if (rst_q) begin
            m_cnt = 0;
            m_err = 1'b0;
         end
         if (exp_wr.size() > 0 && exp_wr[0].cyc == cyc) begin
            e = exp_wr.pop_front();
            chk("we_due", we, 1);
            chk("wAddr", wAddr, e.addr);
            chk("wData", wData, e.dat);
         end else begin
            chk("we_quiet", we, 0);
         end
         if (we) begin
            chk("wAddr_range", (wAddr <= H * V - 1), 1);
            n_wr++;
            last_addr = wAddr;
            if (n_wr == 1) begin
               first_addr = wAddr;
               first_dat  = wData;
               first_cyc  = cyc;
            end
         end
         if (exp_done.size() > 0 && exp_done[0].cyc == cyc) begin
            d = exp_done.pop_front();
            m_cnt = (m_cnt + 1) % 256;
            m_err = d.err;
            chk("frame_done_due", frame_done, 1);
         end else begin
            chk("frame_done_quiet", frame_done, 0);
         end
         if (frame_done) n_done++;
         chk("frame_cnt", frame_cnt, m_cnt);
         chk("frame_err", frame_err, m_err);
      end
   end

   task automatic step();
      @(posedge clk);
      #2;
   endtask

   task automatic clr_obs();
      n_wr = 0; n_done = 0; first_addr = -1; first_dat = -1; first_cyc = -1; last_addr = -1;
   endtask

   task automatic model_reset_assert();
      reset = 1'b1;
      m_active = 1'b0;
      m_seen_rise = 1'b0;
      // Writes from bytes sampled on or after the reset edge never happen
      while (exp_wr.size() > 0 && exp_wr[$].cyc > cyc) void'(exp_wr.pop_back());
      while (exp_done.size() > 0 && exp_done[$].cyc > cyc) void'(exp_done.pop_back());
   endtask

   task automatic vs_rise_now();
      vsync = 1'b1;
      m_seen_rise = 1'b1;
      if (m_active) begin
         exp_done.push_back('{cyc + 1, (m_line_err || m_lines != V)});
         m_active = 1'b0;
      end
   endtask

   task automatic vs_fall_now(input bit en);
      vsync = 1'b0;
      cap_en = en;
      if (m_seen_rise && en) begin
         m_active = 1'b1;
         m_lines = 0;
         m_line_err = 1'b0;
      end
   endtask

   task automatic vs_rise();
      step();
      vs_rise_now();
      repeat (3) step();
   endtask

   task automatic vs_fall(input bit en);
      step();
      vs_fall_now(en);
      repeat (2) step();
   endtask

   // One href-high burst of nbytes; optionally raise vsync on its last byte,
   // optionally assert reset at byte rst_at for two cycles
   task automatic send_line(input int nbytes, input bit vs_last, input int rst_at);
      int npix;
      logic [7:0] d, prev;
      npix = 0;
      prev = 8'd0;
      for (int b = 0; b < nbytes; b++) begin
         step();
         if (b == rst_at) model_reset_assert();
         if (rst_at >= 0 && b == rst_at + 2) reset = 1'b0;
         d = pat(m_lines, b);
         href = 1'b1;
         data = d;
         if (m_active && (b % 2 == 1)) begin
            npix++;
            if (b / 2 < H && m_lines < V)
               exp_wr.push_back('{cyc + 1, m_lines * H + b / 2, int'({prev, d})});
            if (m_lines == 0 && b == 1) lo_cyc = cyc;
         end
         if (vs_last && b == nbytes - 1) vs_rise_now();
         prev = d;
      end
      step();
      href = 1'b0;
      data = 8'd0;
      if (m_active) begin
         if (npix != H) m_line_err = 1'b1;
         m_lines++;
      end
      repeat (2) step();
   endtask

   task automatic full_lines(input int n);
      for (int i = 0; i < n; i++) send_line(2 * H, 1'b0, -1);
   endtask

   initial begin
      // Reset state
      repeat (2) step();
      chk("rst_we", we, 0);
      chk("rst_wAddr", wAddr, 0);
      chk("rst_wData", wData, 0);
      chk("rst_frame_done", frame_done, 0);
      chk("rst_frame_err", frame_err, 0);
      chk("rst_frame_cnt", frame_cnt, 0);
      started = 1'b1;
      reset = 1'b0;
      step();

      // Full clean frame; first pixel F8,1F
      vs_rise();
      vs_fall(1'b1);
      clr_obs();
      full_lines(V);
      vs_rise();
      chk("A_writes", n_wr, 32);
      chk("A_first_addr", first_addr, 0);
      chk("A_first_dat", first_dat, 16'hF81F);
      chk("A_first_lat", first_cyc, lo_cyc + 1);
      chk("A_last_addr", last_addr, 31);
      chk("A_done", n_done, 1);
      chk("A_cnt", frame_cnt, 1);
      chk("A_err", frame_err, 0);

      // Odd-byte line then an overlong line
      vs_fall(1'b1);
      clr_obs();
      send_line(2 * H + 1, 1'b0, -1);
      send_line(2 * H + 2, 1'b0, -1);
      full_lines(V - 2);
      vs_rise();
      chk("B_writes", n_wr, 32);
      chk("B_err", frame_err, 1);
      chk("B_cnt", frame_cnt, 2);

      // Short frame
      vs_fall(1'b1);
      clr_obs();
      full_lines(V - 1);
      vs_rise();
      chk("C_writes", n_wr, 24);
      chk("C_last_addr", last_addr, 23);
      chk("C_done", n_done, 1);
      chk("C_err", frame_err, 1);
      chk("C_cnt", frame_cnt, 3);

      // Capture disabled at the boundary, then resumed with cap_en dropped mid-frame
      vs_fall(1'b0);
      clr_obs();
      full_lines(V);
      vs_rise();
      chk("D0_writes", n_wr, 0);
      chk("D0_done", n_done, 0);
      chk("D0_cnt", frame_cnt, 3);
      vs_fall(1'b1);
      clr_obs();
      full_lines(1);
      step();
      cap_en = 1'b0;
      full_lines(V - 1);
      vs_rise();
      chk("D1_writes", n_wr, 32);
      chk("D1_first_addr", first_addr, 0);
      chk("D1_cnt", frame_cnt, 4);
      chk("D1_err", frame_err, 0);

      // vsync rises together with the final low byte
      vs_fall(1'b1);
      clr_obs();
      full_lines(V - 1);
      send_line(2 * H, 1'b1, -1);
      step();
      chk("E_writes", n_wr, 32);
      chk("E_last_addr", last_addr, 31);
      chk("E_err", frame_err, 1);
      chk("E_cnt", frame_cnt, 5);

      // Reset mid-frame: nothing until a full vsync high->low sequence
      vs_fall(1'b1);
      full_lines(1);
      send_line(2 * H, 1'b0, 5);
      chk("F_cnt_rst", frame_cnt, 0);
      chk("F_err_rst", frame_err, 0);
      clr_obs();
      full_lines(2);
      vs_rise();
      chk("F_writes_pre", n_wr, 0);
      chk("F_done_pre", n_done, 0);
      vs_fall(1'b1);
      full_lines(V);
      vs_rise();
      chk("F_writes", n_wr, 32);
      chk("F_first_addr", first_addr, 0);
      chk("F_cnt", frame_cnt, 1);
      chk("F_err", frame_err, 0);

      repeat (3) step();
      chk("exp_wr_left", exp_wr.size(), 0);
      chk("exp_done_left", exp_done.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/cam_capture.md
CAM_CAPTURE -- requirements
Module: cam_capture

Interface
REQ-001 The module SHALL take parameter H_PIX, default 320, meaning active pixels per line.
REQ-002 The module SHALL take parameter V_LINES, default 240, meaning active lines per frame.
REQ-003 The module SHALL have port clk, input, 1 bit: the single clock, which is the camera pixel clock; all logic is on its rising edge.
REQ-004 The module SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-005 The module SHALL have port cap_en, input, 1 bit: permits capture to start at the next frame boundary.
REQ-006 The module SHALL have port vsync, input, 1 bit: camera frame sync; high = vertical blanking.
REQ-007 The module SHALL have port href, input, 1 bit: camera line-valid; high = active bytes on data.
REQ-008 The module SHALL have port data, input, 8 bits: camera byte stream, RGB565, high byte first.
REQ-009 The module SHALL have port we, output, 1 bit: frame-buffer write strobe, one cycle per pixel.
REQ-010 The module SHALL have port wAddr, output, 17 bits: frame-buffer write address.
REQ-011 The module SHALL have port wData, output, 16 bits: RGB565 pixel.
REQ-012 The module SHALL have port frame_done, output, 1 bit: one-cycle pulse at the end of each captured frame.
REQ-013 The module SHALL have port frame_err, output, 1 bit: registered flag; the last frame was not exactly H_PIX x V_LINES pixels.
REQ-014 The module SHALL have port frame_cnt, output, 8 bits: count of completed frames, wrapping.

Function
REQ-015 The FSM SHALL have states S_IDLE, S_BLANK and S_ACTIVE; reset enters S_IDLE.
REQ-016 S_IDLE SHALL go to S_BLANK on a vsync rising edge, so the partial frame present at reset is discarded.
REQ-017 S_BLANK SHALL go to S_ACTIVE on a vsync falling edge only if cap_en=1 in that cycle; otherwise it stays in S_BLANK.
REQ-018 S_ACTIVE SHALL go to S_BLANK on a vsync rising edge, pulse frame_done in the same cycle, and increment frame_cnt.
REQ-019 vsync edges SHALL be detected against a one-cycle-delayed copy of vsync; href and data SHALL be used as sampled, with no extra synchronizer.
REQ-020 In S_ACTIVE with href=1, bytes SHALL alternate by phase: phase 0 latches data as wData[15:8], phase 1 supplies wData[7:0] and completes the pixel.
REQ-021 The byte phase SHALL clear whenever href=0; an odd trailing byte at the href falling edge SHALL be dropped without a write.
REQ-022 A completed pixel SHALL assert we, wAddr and wData registered in the cycle after the phase-1 byte is sampled (latency 1), with we high for exactly one cycle.
REQ-023 wAddr SHALL equal y*H_PIX+x, generated by an incrementing counter with no multiplier, starting at 0 on entry to S_ACTIVE.
REQ-024 Pixels with x>=H_PIX on a line SHALL NOT be written (we=0) but SHALL be counted as an error condition.
REQ-025 On an href falling edge, x SHALL return to 0 and y SHALL increment, saturating at V_LINES.
REQ-026 Pixels with y>=V_LINES SHALL NOT be written; wAddr SHALL never exceed H_PIX*V_LINES-1.
REQ-027 frame_err SHALL update at frame_done: 1 if any line had x!=H_PIX at href fall or the line count !=V_LINES, else 0.
REQ-028 Dropping cap_en during S_ACTIVE SHALL NOT abort the frame; it only blocks the next S_BLANK->S_ACTIVE transition.
REQ-029 A vsync rise in the same cycle as a phase-1 byte SHALL complete that pixel write (if in range) and then leave S_ACTIVE.

Reset
REQ-030 Reset SHALL set we=0, wAddr=0, wData=0, frame_done=0, frame_err=0, frame_cnt=0, x=y=0, phase=0 and state S_IDLE.
REQ-031 Reset asserted mid-frame SHALL suppress all writes from the next edge onward; capture resumes only after a full vsync high->low sequence.

Structure
REQ-032 A shared package cam_pkg SHALL hold the state enum, the H_PIX/V_LINES defaults and the address width (17).
REQ-033 The module SHALL be one flat module; no sub-module is required.

Verification
REQ-034 Reset, vsync pulse, cap_en=1, 240 lines of 640 bytes -> 76800 writes, wAddr 0..76799 in order, frame_done once, frame_err=0, frame_cnt=1.
REQ-035 Byte pair 0xF8,0x1F on line 0 -> we one cycle after the 0x1F byte, wAddr=0, wData=0xF81F.
REQ-036 A line of 641 bytes then a line of 642 bytes -> first line 320 writes with the odd byte dropped; second line 320 writes, 321st pixel suppressed, frame_err=1 at frame_done.
REQ-037 Reset released mid-frame -> zero writes until vsync rises then falls; the next frame is captured normally.
REQ-038 cap_en=0 at the vsync falling edge -> no writes for that frame and no frame_done; cap_en=1 at the next boundary -> capture resumes from wAddr=0.
REQ-039 Only 239 lines delivered, then vsync rises -> frame_done pulses, frame_err=1, last wAddr=76479.
